// File: rtl/bp_resolve_ctrl_if.sv
// Bundle of fetch-side alloc, execute-side resolve, predictor update and
// redirect signals for the in-flight branch tracker.
interface bp_resolve_ctrl_if #(
  parameter int HISTORY_BITS = 8,
  parameter int TW           = 3
);
  // Fetch registers a predicted branch
  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [31:0]             alloc_pc;
  logic                    alloc_pred_taken;
  logic [31:0]             alloc_pred_target;
  logic [HISTORY_BITS-1:0] alloc_ghr;
  logic [TW-1:0]           alloc_tag;

  // Execute resolves a branch in program order
  logic                    resolve_valid;
  logic [TW-1:0]           resolve_tag;
  logic                    resolve_taken;
  logic [31:0]             resolve_target;

  // Predictor update port
  logic                    bp_update_en;
  logic [31:0]             bp_update_pc;
  logic                    bp_update_taken;
  logic [31:0]             bp_update_target;
  logic                    bp_mispredict;
  logic [HISTORY_BITS-1:0] bp_recover_ghr;

  // Fetch redirect and status
  logic                    redirect_valid;
  logic [31:0]             redirect_pc;
  logic [TW:0]             count;
  logic                    order_err;

  // Driver side: fetch/execute stimulus, observes tracker outputs
  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_ghr,
    output resolve_valid, resolve_tag, resolve_taken, resolve_target,
    input  alloc_ready, alloc_tag,
    input  bp_update_en, bp_update_pc, bp_update_taken, bp_update_target,
    input  bp_mispredict, bp_recover_ghr,
    input  redirect_valid, redirect_pc, count, order_err
  );

  // Tracker side
  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_ghr,
    input  resolve_valid, resolve_tag, resolve_taken, resolve_target,
    output alloc_ready, alloc_tag,
    output bp_update_en, bp_update_pc, bp_update_taken, bp_update_target,
    output bp_mispredict, bp_recover_ghr,
    output redirect_valid, redirect_pc, count, order_err
  );
endinterface

// File: rtl/bp_resolve_ctrl.sv
// In-flight branch tracker: circular buffer of predicted branches, resolved
// in program order; drives the predictor update port, flushes younger
// entries on a mispredict and redirects fetch to the correct-path PC.
module bp_resolve_ctrl #(
  parameter int DEPTH        = 8,
  parameter int HISTORY_BITS = 8,
  parameter int TW           = $clog2(DEPTH)
) (
  input logic clock,
  input logic reset,
  bp_resolve_ctrl_if.slave bus
);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  // Per-slot branch record
  logic [31:0]             pc_mem     [DEPTH];
  logic                    taken_mem  [DEPTH];
  logic [31:0]             target_mem [DEPTH];
  logic [HISTORY_BITS-1:0] ghr_mem    [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [TW:0] head_reg, head_next;
  logic [TW:0] tail_reg, tail_next;
  logic [TW:0] count_reg, count_next;
  logic [0:0]  state_reg, state_next;

  logic full;
  logic empty;
  logic alloc_fire;
  logic resolve_hit;
  logic resolve_bad;
  logic mispredict;

  logic [TW-1:0]           head_idx;
  logic [31:0]             head_pc;
  logic                    head_taken;
  logic [31:0]             head_target;
  logic [HISTORY_BITS-1:0] head_ghr;
  logic [31:0]             correct_pc;
  logic [DEPTH-1:0]        slot_we;

  // Registered outputs
  logic                    update_en_reg;
  logic [31:0]             update_pc_reg;
  logic                    update_taken_reg;
  logic [31:0]             update_target_reg;
  logic                    mispredict_reg;
  logic [HISTORY_BITS-1:0] recover_ghr_reg;
  logic                    redirect_valid_reg;
  logic [31:0]             redirect_pc_reg;
  logic                    order_err_reg;

  assign full  = (head_reg[TW] != tail_reg[TW]) && (head_reg[TW-1:0] == tail_reg[TW-1:0]);
  assign empty = (head_reg == tail_reg);

  // Ready is combinational so fetch sees back-pressure in the same cycle
  assign bus.alloc_ready = !full && (state_reg == NORMAL) && !reset;
  assign bus.alloc_tag   = tail_reg[TW-1:0];

  assign alloc_fire = bus.alloc_valid && bus.alloc_ready;

  // Only the oldest branch may resolve; stale tags during recovery are dropped quietly
  assign resolve_hit = bus.resolve_valid && (state_reg == NORMAL) && !empty &&
                       (bus.resolve_tag == head_reg[TW-1:0]);
  assign resolve_bad = bus.resolve_valid && (state_reg == NORMAL) &&
                       (empty || (bus.resolve_tag != head_reg[TW-1:0]));

  assign head_idx    = head_reg[TW-1:0];
  assign head_pc     = pc_mem[head_idx];
  assign head_taken  = taken_mem[head_idx];
  assign head_target = target_mem[head_idx];
  assign head_ghr    = ghr_mem[head_idx];

  // Wrong direction, or right direction but wrong taken target
  assign mispredict = (bus.resolve_taken != head_taken) ||
                      (bus.resolve_taken && (bus.resolve_target != head_target));

  assign correct_pc = bus.resolve_taken ? bus.resolve_target : (head_pc + 32'd4);

  // One write enable per slot, selected by the tail index
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_we[gi] = alloc_fire && (tail_reg[TW-1:0] == TW'(gi));

      // Capture the branch record when this slot is allocated
      always_ff @(posedge clock) begin
        if (slot_we[gi]) begin
          pc_mem[gi]     <= bus.alloc_pc;
          taken_mem[gi]  <= bus.alloc_pred_taken;
          target_mem[gi] <= bus.alloc_pred_target;
          ghr_mem[gi]    <= bus.alloc_ghr;
        end
      end
    end
  endgenerate

  // Next pointer, occupancy and state; a flush overrides a same-cycle alloc
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    state_next = NORMAL;
    if (alloc_fire) begin
      tail_next = tail_reg + 1'b1;
    end
    if (resolve_hit) begin
      head_next = head_reg + 1'b1;
      if (mispredict) begin
        tail_next  = head_reg + 1'b1;
        state_next = RECOVER;
      end
    end
    count_next = tail_next - head_next;
  end

  // Pointer, FSM and occupancy registers
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= NORMAL;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      state_reg <= state_next;
    end
  end

  // Predictor update / redirect outputs; data fields hold between strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      update_en_reg      <= 1'b0;
      update_pc_reg      <= '0;
      update_taken_reg   <= 1'b0;
      update_target_reg  <= '0;
      mispredict_reg     <= 1'b0;
      recover_ghr_reg    <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      order_err_reg      <= 1'b0;
    end else begin
      update_en_reg      <= resolve_hit;
      mispredict_reg     <= resolve_hit && mispredict;
      redirect_valid_reg <= resolve_hit && mispredict;
      if (resolve_hit) begin
        update_pc_reg     <= head_pc;
        update_taken_reg  <= bus.resolve_taken;
        update_target_reg <= bus.resolve_target;
        recover_ghr_reg   <= head_ghr;
      end
      if (resolve_hit && mispredict) begin
        redirect_pc_reg <= correct_pc;
      end
      if (resolve_bad) begin
        order_err_reg <= 1'b1;
      end
    end
  end

  assign bus.bp_update_en     = update_en_reg;
  assign bus.bp_update_pc     = update_pc_reg;
  assign bus.bp_update_taken  = update_taken_reg;
  assign bus.bp_update_target = update_target_reg;
  assign bus.bp_mispredict    = mispredict_reg;
  assign bus.bp_recover_ghr   = recover_ghr_reg;
  assign bus.redirect_valid   = redirect_valid_reg;
  assign bus.redirect_pc      = redirect_pc_reg;
  assign bus.count            = count_reg;
  assign bus.order_err        = order_err_reg;

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Directed bench for bp_resolve_ctrl with a reference model of the buffer
// and a scoreboard of expected predictor updates.
module tb_bp_resolve_ctrl;

  localparam int DEPTH = 8;
  localparam int HB    = 8;
  localparam int TW    = 3;

  logic clock;
  logic reset;

  bp_resolve_ctrl_if #(.HISTORY_BITS(HB), .TW(TW)) ifc ();

  bp_resolve_ctrl #(.DEPTH(DEPTH), .HISTORY_BITS(HB), .TW(TW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic [7:0]  ghr;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  ghr;
    logic        mis;
    logic [31:0] rpc;
  } exp_t;

  ent_t m_q[$];
  exp_t exp_q[$];
  logic [3:0] m_head;
  logic [3:0] m_tail;
  logic       m_rec;
  logic       m_err;

  int total_checks = 0;
  int fail_checks  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      fail_checks++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc.alloc_valid       = 1'b0;
    ifc.alloc_pc          = '0;
    ifc.alloc_pred_taken  = 1'b0;
    ifc.alloc_pred_target = '0;
    ifc.alloc_ghr         = '0;
    ifc.resolve_valid     = 1'b0;
    ifc.resolve_tag       = '0;
    ifc.resolve_taken     = 1'b0;
    ifc.resolve_target    = '0;
  endtask

  // Hold reset for n cycles, then release and check the reset state
  task automatic do_reset(input int n);
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      chk("ready_in_reset", ifc.alloc_ready, 1'b0);
      chk("upd_in_reset", ifc.bp_update_en, 1'b0);
    end
    reset = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_head = '0;
    m_tail = '0;
    m_rec  = 1'b0;
    m_err  = 1'b0;
    #1;
    chk("rst_count", ifc.count, 0);
    chk("rst_ready", ifc.alloc_ready, 1'b1);
    chk("rst_mispredict", ifc.bp_mispredict, 1'b0);
    chk("rst_redirect", ifc.redirect_valid, 1'b0);
    chk("rst_order_err", ifc.order_err, 1'b0);
    chk("rst_redirect_pc", ifc.redirect_pc, 0);
  endtask

  // One clock of stimulus; model predicts acceptance, scoreboard checks outputs
  task automatic cycle(input logic av, input logic [31:0] apc, input logic apt,
                       input logic [31:0] atgt, input logic [7:0] aghr,
                       input logic rv, input logic [2:0] rtag, input logic rt,
                       input logic [31:0] rtgt);
    logic a_rdy, a_acc, r_ok, r_bad, mis;
    ent_t ne;
    exp_t e;
    ifc.alloc_valid       = av;
    ifc.alloc_pc          = apc;
    ifc.alloc_pred_taken  = apt;
    ifc.alloc_pred_target = atgt;
    ifc.alloc_ghr         = aghr;
    ifc.resolve_valid     = rv;
    ifc.resolve_tag       = rtag;
    ifc.resolve_taken     = rt;
    ifc.resolve_target    = rtgt;
    #1;
    a_rdy = (m_q.size() < DEPTH) && !m_rec;
    chk("alloc_ready", ifc.alloc_ready, a_rdy);
    if (av) chk("alloc_tag", ifc.alloc_tag, m_tail[2:0]);
    a_acc = av && a_rdy;
    r_ok  = rv && !m_rec && (m_q.size() > 0) && (rtag == m_head[2:0]);
    r_bad = rv && !m_rec && !r_ok;
    mis   = 1'b0;
    if (r_ok) begin
      mis = (rt != m_q[0].pt) || (rt && (rtgt != m_q[0].tgt));
      e.pc     = m_q[0].pc;
      e.taken  = rt;
      e.target = rtgt;
      e.ghr    = m_q[0].ghr;
      e.mis    = mis;
      e.rpc    = rt ? rtgt : (m_q[0].pc + 32'd4);
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    if (a_acc) begin
      ne.pc  = apc;
      ne.pt  = apt;
      ne.tgt = atgt;
      ne.ghr = aghr;
      m_q.push_back(ne);
      m_tail = m_tail + 1'b1;
    end
    if (r_ok) begin
      void'(m_q.pop_front());
      m_head = m_head + 1'b1;
      if (mis) begin
        m_q.delete();
        m_tail = m_head;
      end
    end
    m_rec = r_ok && mis;
    m_err = m_err | r_bad;
    idle_inputs();
    chk("count", ifc.count, m_q.size());
    chk("order_err", ifc.order_err, m_err);
    chk("update_en", ifc.bp_update_en, exp_q.size() != 0);
    if (ifc.bp_update_en === 1'b1 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("upd_pc", ifc.bp_update_pc, e.pc);
      chk("upd_taken", ifc.bp_update_taken, e.taken);
      chk("upd_target", ifc.bp_update_target, e.target);
      chk("recover_ghr", ifc.bp_recover_ghr, e.ghr);
      chk("mispredict", ifc.bp_mispredict, e.mis);
      chk("redirect_valid", ifc.redirect_valid, e.mis);
      if (e.mis) chk("redirect_pc", ifc.redirect_pc, e.rpc);
    end else begin
      exp_q.delete();
      chk("mispredict_idle", ifc.bp_mispredict, 1'b0);
      chk("redirect_idle", ifc.redirect_valid, 1'b0);
    end
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                       input logic [7:0] ghr);
    cycle(1'b1, pc, pt, tgt, ghr, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic resolve(input logic [2:0] tag, input logic rt, input logic [31:0] rtgt);
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, tag, rt, rtgt);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] spc, stgt;
    logic        spt;
    reset = 1'b1;
    idle_inputs();

    // Reset, then idle
    do_reset(2);
    idle();
    idle();

    // Fill all eight slots; a ninth alloc is held off
    for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 8'(i));
    alloc(32'h2000, 1'b0, 32'h0, 8'h11);
    alloc(32'h2000, 1'b0, 32'h0, 8'h11);

    // Full: correct resolve with simultaneous alloc, alloc refused, 8 -> 7
    cycle(1'b1, 32'h2000, 1'b0, 32'h0, 8'h11, 1'b1, m_head[2:0], 1'b0, 32'h0);
    while (m_q.size() > 0) resolve(m_head[2:0], 1'b0, 32'h0);

    // Correctly predicted taken branch
    alloc(32'h100, 1'b1, 32'h200, 8'hA5);
    resolve(m_head[2:0], 1'b1, 32'h200);

    // Direction mispredict: flush, redirect to pc+4, one recovery cycle
    alloc(32'h40, 1'b1, 32'h80, 8'h3C);
    alloc(32'h44, 1'b0, 32'h0, 8'h3D);
    alloc(32'h48, 1'b0, 32'h0, 8'h3E);
    cycle(1'b1, 32'h900, 1'b0, 32'h0, 8'h00, 1'b1, m_head[2:0], 1'b0, 32'h0);
    resolve(m_head[2:0], 1'b0, 32'h0);
    idle();

    // Taken-target mispredict, then not-taken at the top of the address space
    alloc(32'h300, 1'b1, 32'h400, 8'h5A);
    resolve(m_head[2:0], 1'b1, 32'h500);
    idle();
    alloc(32'hFFFF_FFFC, 1'b1, 32'h10, 8'hC3);
    resolve(m_head[2:0], 1'b0, 32'h0);
    idle();

    // Stream 20 alloc/resolve pairs; tags wrap around the buffer
    for (int i = 0; i < 20; i++) begin
      spc  = $urandom;
      spt  = 1'($urandom_range(0, 1));
      stgt = $urandom;
      if (m_q.size() > 0)
        cycle(1'b1, spc, spt, stgt, 8'($urandom), 1'b1, m_head[2:0], m_q[0].pt,
              m_q[0].pt ? m_q[0].tgt : 32'($urandom));
      else
        alloc(spc, spt, stgt, 8'($urandom));
    end
    resolve(m_head[2:0], m_q[0].pt, m_q[0].tgt);

    // Reset mid-operation drops in-flight branches with no update pulse
    alloc(32'h600, 1'b0, 32'h0, 8'h01);
    alloc(32'h604, 1'b0, 32'h0, 8'h02);
    do_reset(1);
    idle();

    // Out-of-order tag sets the sticky error
    alloc(32'h700, 1'b0, 32'h0, 8'h01);
    alloc(32'h704, 1'b0, 32'h0, 8'h02);
    alloc(32'h708, 1'b0, 32'h0, 8'h03);
    resolve(m_head[2:0] + 3'd2, 1'b0, 32'h0);
    idle();
    do_reset(1);

    // Resolve on an empty buffer sets it too, and it stays set
    resolve(3'd0, 1'b0, 32'h0);
    idle();
    alloc(32'h800, 1'b0, 32'h0, 8'h07);
    resolve(m_head[2:0], 1'b0, 32'h0);
    idle();

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
